bs_if_fifo: RTL and testbench
=============================

# bs_if_fifo

Per-driver endpoint interface for the serial/parallel bus generator (`bs_gnrtr`); one instance sits on each of the generator's `DRVRS` ports.
- Toward the bus it provides the outbound queue: `pndng` / `pop` / `D_pop`.
- It accepts inbound packets through `push` / `D_push`.
- Toward the local device it exposes valid/ready transmit and receive streams.
- Inbound packets are address-filtered, and inbound packets that overflow the receive queue are dropped and counted.

## Interface
Parameters
- `PCKG_SZ`, 128: packet width in bits. Header is {target[8], source[8], id[16]} in the MSBs; payload is `PCKG_SZ-32` bits.
- `DEPTH`, 16: entries per queue. Must be a power of two and ≥ 2.
- `ID`, 0: this endpoint's 8-bit address.
- `BROADCAST`, 8'hFF: target value accepted by every endpoint.

Ports
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `pndng`  out  1  outbound queue non-empty.
- `pop`  in  1  bus consumes the head of the outbound queue.
- `D_pop`  out  `PCKG_SZ`  head of the outbound queue; all zeros when empty.
- `push`  in  1  bus delivers a packet on `D_push`.
- `D_push`  in  `PCKG_SZ`  inbound packet.
- `tx_vld`  in  1  device offers `tx_data`.
- `tx_rdy`  out  1  outbound queue can accept a packet.
- `tx_data`  in  `PCKG_SZ`  outbound packet from the device.
- `rx_vld`  out  1  inbound queue non-empty.
- `rx_rdy`  in  1  device consumes `rx_data`.
- `rx_data`  out  `PCKG_SZ`  head of the inbound queue; all zeros when empty.
- `rx_drop_cnt`  out  16  count of inbound packets dropped on a full queue; saturates at 16'hFFFF.

## Operation
- **Queues:** both are first-word-fall-through. Pointers are `$clog2(DEPTH)+1` bits wide, and the extra MSB distinguishes full from empty on wrap-around.
- **TX write:** an entry is written on `tx_vld && tx_rdy`. `tx_rdy = !tx_full`.
- **TX read:** the head advances on `pop && pndng`. `pop` while empty is ignored, with no state change.
- **TX full:** a simultaneous pop frees a slot, but `tx_rdy` was already low that cycle, so no write occurs.
- **RX accept rule:** a packet on `push` is accepted if `D_push[PCKG_SZ-1 -: 8]` is `ID` or `BROADCAST` (see Configuration).
- **RX filtered out:** a non-matching packet is discarded silently and is not counted.
- **RX full:** the bus side has no backpressure.
  - An accepted push into a full queue with no same-cycle pop is dropped, and `rx_drop_cnt` increments (saturating).
  - An accepted push into a full queue with a same-cycle `rx_vld && rx_rdy` pop is stored, and occupancy stays `DEPTH`.
- **RX read:** the head advances on `rx_vld && rx_rdy`.
- **Reset:** asserting `reset` mid-operation empties both queues immediately. Queue contents are not cleared, but the outputs mask them to zero.

## Timing
- **Reset values:**
  - `pndng` = 0, `D_pop` = 0, `tx_rdy` = 1.
  - `rx_vld` = 0, `rx_data` = 0, `rx_drop_cnt` = 0.
- **Latency:** a write at edge N shows on `pndng` / `D_pop` (or `rx_vld` / `rx_data`) after edge N; this is the first cycle it is visible. One cycle, write to visible.
- **Pop:** a pop at edge N presents the next head (or empty) after edge N.
- **Status timing:** `tx_rdy`, `pndng` and `rx_vld` are registered-state derived. They are combinational from the pointers only, with no combinational path from any input.
- **Throughput:** sustained one write plus one read per cycle on each queue.

## Configuration
- Macro: `BS_IF_ADDR_FILTER_EN`.
- **Defined:** the accept rule above applies.
- **Undefined:** every inbound push is accepted regardless of target. The comparator is removed, and behaviour on a full queue is unchanged.

## Structure
- **Shared package `bs_pkg`:** holds
  - the `BROADCAST` default;
  - the field offsets `TGT_MSB`, `SRC_MSB`, `ID_MSB`, `HDR_SZ=32`;
  - a packed header typedef `bs_hdr_t` {target, source, id};
  - a function `bs_addr_match(hdr, id)`.
- **Sub-module `bs_sync_fifo`:** parameters `WIDTH`, `DEPTH`; ports `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`. It is FWFT and instantiated twice.
  - The top level keeps the filter, the drop counter and the output masking.

## Test plan
- **TX fill and drain:** after reset, drive `tx_vld` = 1 for 17 cycles with ids 0..16, `DEPTH` = 16.
  - `tx_rdy` drops after 16 writes and id 16 is not taken.
  - `pop` 16 times yields ids 0..15 in order; then `pndng` = 0 and `D_pop` = 0.
- **Address filter:** `ID` = 1, with the macro defined. Push targets 8'h01, 8'h02 and 8'hFF.
  - Exactly two entries appear on `rx_data`, targets 01 then FF.
  - `rx_drop_cnt` = 0.
- **RX overflow:** `rx_rdy` = 0, push 20 matching packets.
  - `rx_vld` = 1 and occupancy is 16.
  - `rx_drop_cnt` = 4; draining yields the first 16 ids.
- **Full with simultaneous pop:** fill RX to 16, then push id 99 with `rx_rdy` = 1 in the same cycle.
  - The count stays 16, `rx_drop_cnt` is unchanged, and id 99 is last out.
- **Wrap-around and mid-operation reset:**
  - Stream 40 packets through TX with `pop` every cycle; ids arrive in order with one-cycle latency.
  - Assert `reset` mid-stream: `pndng` = 0 and `rx_vld` = 0 at once, and `tx_rdy` = 1 while `reset` is deasserted.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared definitions for the bs_gnrtr endpoint blocks: packet header
// layout, the broadcast address and the inbound address-match helper.
package bs_pkg;

  localparam logic [7:0] BS_BROADCAST = 8'hFF;

  // Header field positions, counted from the header LSB.
  localparam int HDR_SZ  = 32;
  localparam int TGT_MSB = 31;
  localparam int SRC_MSB = 23;
  localparam int ID_MSB  = 15;

  typedef struct packed {
    logic [7:0]  target;
    logic [7:0]  source;
    logic [15:0] id;
  } bs_hdr_t;

  // An endpoint takes a packet aimed at its own address or at broadcast.
  function automatic logic bs_addr_match(input bs_hdr_t    hdr,
                                         input logic [7:0] id,
                                         input logic [7:0] bcast = BS_BROADCAST);
    return (hdr.target == id) || (hdr.target == bcast);
  endfunction

endpackage

// File: rtl/bs_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is always
// visible on rd_data; pointers carry one extra wrap bit to tell full from
// empty. The caller must not write while full unless it also reads in the
// same cycle (the freed head slot is then overwritten).
module bs_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Storage is deliberately not reset; empty pointers make old data invisible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer update; reset empties the queue at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/bs_if_fifo.sv
// Per-driver endpoint for bs_gnrtr: outbound queue toward the bus, inbound
// queue toward the device, inbound address filter and overflow counter.
// Optional build macro BS_IF_ADDR_FILTER_EN enables the target-address
// filter; without it every inbound push is accepted.
module bs_if_fifo
  import bs_pkg::*;
#(
  parameter int         PCKG_SZ   = 128,
  parameter int         DEPTH     = 16,
  parameter logic [7:0] ID        = 8'd0,
  parameter logic [7:0] BROADCAST = BS_BROADCAST
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  input  logic               pop,
  output logic [PCKG_SZ-1:0] D_pop,
  input  logic               push,
  input  logic [PCKG_SZ-1:0] D_push,
  input  logic               tx_vld,
  output logic               tx_rdy,
  input  logic [PCKG_SZ-1:0] tx_data,
  output logic               rx_vld,
  input  logic               rx_rdy,
  output logic [PCKG_SZ-1:0] rx_data,
  output logic [15:0]        rx_drop_cnt
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("bs_if_fifo: DEPTH must be a power of two and at least 2");
  end
  if (ID == BROADCAST) begin : g_bad_id
    $error("bs_if_fifo: ID must differ from the broadcast address");
  end
  if (PCKG_SZ <= HDR_SZ) begin : g_bad_size
    $error("bs_if_fifo: PCKG_SZ must leave room for a payload");
  end

  logic               tx_full, tx_empty, tx_wr, tx_rd;
  logic [PCKG_SZ-1:0] tx_head;
  logic               rx_full, rx_empty, rx_wr, rx_rd;
  logic [PCKG_SZ-1:0] rx_head;
  logic               rx_accept;
  logic               rx_drop;

  assign tx_rdy = !tx_full;
  assign tx_wr  = tx_vld && !tx_full;
  assign tx_rd  = pop && !tx_empty;

  bs_sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_wr),
    .wr_data (tx_data),
    .rd_en   (tx_rd),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

`ifdef BS_IF_ADDR_FILTER_EN
  bs_hdr_t in_hdr;
  assign in_hdr    = D_push[PCKG_SZ-1 -: HDR_SZ];
  assign rx_accept = push && bs_addr_match(in_hdr, ID, BROADCAST);
`else
  assign rx_accept = push;
`endif

  // The bus cannot be stalled: a full queue still takes a packet if the
  // device frees the head in the same cycle, otherwise the packet is lost.
  assign rx_rd   = rx_rdy && !rx_empty;
  assign rx_wr   = rx_accept && (!rx_full || rx_rd);
  assign rx_drop = rx_accept && rx_full && !rx_rd;

  bs_sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_wr),
    .wr_data (D_push),
    .rd_en   (rx_rd),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // Saturating count of accepted inbound packets lost to a full queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_drop_cnt <= '0;
    end else if (rx_drop && (rx_drop_cnt != 16'hFFFF)) begin
      rx_drop_cnt <= rx_drop_cnt + 16'd1;
    end
  end

  assign pndng   = !tx_empty;
  assign D_pop   = tx_empty ? '0 : tx_head;
  assign rx_vld  = !rx_empty;
  assign rx_data = rx_empty ? '0 : rx_head;

endmodule

// File: tb/tb_bs_if_fifo.sv
// Directed testbench for bs_if_fifo (ID = 1). Expected packets are queued
// in a scoreboard when driven and compared as the DUT presents them.
module tb_bs_if_fifo;

  localparam int PW = 128;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pndng;
  logic          pop = 1'b0;
  logic [PW-1:0] D_pop;
  logic          push = 1'b0;
  logic [PW-1:0] D_push = '0;
  logic          tx_vld = 1'b0;
  logic          tx_rdy;
  logic [PW-1:0] tx_data = '0;
  logic          rx_vld;
  logic          rx_rdy = 1'b0;
  logic [PW-1:0] rx_data;
  logic [15:0]   rx_drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] tx_q[$];
  logic [PW-1:0] rx_q[$];
  logic [PW-1:0] exp_pkt;
  int            tx_cnt;
  int            drop_exp;

  always #5 clk = ~clk;

  bs_if_fifo #(.PCKG_SZ(PW), .DEPTH(DP), .ID(8'h01), .BROADCAST(8'hFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .pndng       (pndng),
    .pop         (pop),
    .D_pop       (D_pop),
    .push        (push),
    .D_push      (D_push),
    .tx_vld      (tx_vld),
    .tx_rdy      (tx_rdy),
    .tx_data     (tx_data),
    .rx_vld      (rx_vld),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .rx_drop_cnt (rx_drop_cnt)
  );

  function automatic logic [PW-1:0] mk_pkt(input logic [7:0] tgt, input logic [15:0] id);
    return {tgt, 8'h5A, id, {3{16'hC0DE, id}}};
  endfunction

  function automatic bit model_accept(input logic [7:0] tgt);
`ifdef BS_IF_ADDR_FILTER_EN
    return (tgt == 8'h01) || (tgt == 8'hFF);
`else
    return 1'b1;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic t_vld, input logic [PW-1:0] t_data, input logic p_pop,
                               input logic p_push, input logic [PW-1:0] p_data, input logic r_rdy);
    tx_vld  = t_vld;
    tx_data = t_data;
    pop     = p_pop;
    push    = p_push;
    D_push  = p_data;
    rx_rdy  = r_rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_rx(input string tag);
    while (rx_q.size() > 0) begin
      exp_pkt = rx_q.pop_front();
      checkOutput({tag, "_vld"}, PW'(rx_vld), PW'(1'b1));
      checkOutput({tag, "_data"}, rx_data, exp_pkt);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput({tag, "_empty"}, PW'(rx_vld), PW'(1'b0));
    checkOutput({tag, "_zero"}, rx_data, '0);
  endtask

  initial begin
    $display("[TB] start");
    drop_exp = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pndng", PW'(pndng), PW'(1'b0));
    checkOutput("rst_dpop", D_pop, '0);
    checkOutput("rst_txrdy", PW'(tx_rdy), PW'(1'b1));
    checkOutput("rst_rxvld", PW'(rx_vld), PW'(1'b0));
    checkOutput("rst_rxdata", rx_data, '0);
    checkOutput("rst_drop", PW'(rx_drop_cnt), PW'(0));
    reset = 1'b1;
    tick();

    // TX fill: 17 offers, only 16 fit
    tx_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      checkOutput("fill_txrdy", PW'(tx_rdy), PW'(tx_cnt < DP));
      applyStimulus(1'b1, mk_pkt(8'h02, 16'(i)), 1'b0, 1'b0, '0, 1'b0);
      if (tx_cnt < DP) begin
        tx_q.push_back(mk_pkt(8'h02, 16'(i)));
        tx_cnt++;
      end
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("full_txrdy", PW'(tx_rdy), PW'(1'b0));
    while (tx_q.size() > 0) begin
      exp_pkt = tx_q.pop_front();
      checkOutput("drain_pndng", PW'(pndng), PW'(1'b1));
      checkOutput("drain_dpop", D_pop, exp_pkt);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      tick();
    end
    // pop on empty keeps going one more cycle and must be harmless
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("empty_pndng", PW'(pndng), PW'(1'b0));
    checkOutput("empty_dpop", D_pop, '0);
    checkOutput("empty_txrdy", PW'(tx_rdy), PW'(1'b1));

    // Address filter: targets 01, 02, FF
    for (int i = 0; i < 3; i++) begin
      logic [7:0] tgt;
      tgt = (i == 0) ? 8'h01 : ((i == 1) ? 8'h02 : 8'hFF);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, mk_pkt(tgt, 16'(100 + i)), 1'b0);
      if (model_accept(tgt)) rx_q.push_back(mk_pkt(tgt, 16'(100 + i)));
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    drain_rx("filt");
    checkOutput("filt_drop", PW'(rx_drop_cnt), PW'(0));

    // RX overflow: 20 pushes with the device stalled
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, mk_pkt(8'h01, 16'(i)), 1'b0);
      if (rx_q.size() < DP) rx_q.push_back(mk_pkt(8'h01, 16'(i)));
      else drop_exp++;
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("ovf_vld", PW'(rx_vld), PW'(1'b1));
    checkOutput("ovf_drop", PW'(rx_drop_cnt), PW'(drop_exp));
    drain_rx("ovf");

    // Full RX with a same-cycle pop: id 99 must be stored, not dropped
    for (int i = 0; i < DP; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, mk_pkt(8'hFF, 16'(200 + i)), 1'b0);
      rx_q.push_back(mk_pkt(8'hFF, 16'(200 + i)));
      tick();
    end
    exp_pkt = rx_q.pop_front();
    checkOutput("fp_head", rx_data, exp_pkt);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, mk_pkt(8'h01, 16'd99), 1'b1);
    rx_q.push_back(mk_pkt(8'h01, 16'd99));
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("fp_drop", PW'(rx_drop_cnt), PW'(drop_exp));
    drain_rx("fp");

    // Streaming through TX with pop every cycle, pointers wrap twice
    for (int i = 0; i < 40; i++) begin
      checkOutput("strm_pndng", PW'(pndng), PW'(tx_q.size() > 0));
      checkOutput("strm_txrdy", PW'(tx_rdy), PW'(1'b1));
      if (tx_q.size() > 0) begin
        exp_pkt = tx_q.pop_front();
        checkOutput("strm_dpop", D_pop, exp_pkt);
      end
      applyStimulus(1'b1, mk_pkt(8'h03, 16'(300 + i)), (i > 0), 1'b0, '0, 1'b0);
      tx_q.push_back(mk_pkt(8'h03, 16'(300 + i)));
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1, mk_pkt(8'hFF, 16'd77), 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("pre_rst_dpop", D_pop, tx_q[0]);
    checkOutput("pre_rst_rxdata", rx_data, mk_pkt(8'hFF, 16'd77));

    // Asynchronous reset in the middle of a cycle
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_pndng", PW'(pndng), PW'(1'b0));
    checkOutput("arst_dpop", D_pop, '0);
    checkOutput("arst_rxvld", PW'(rx_vld), PW'(1'b0));
    checkOutput("arst_rxdata", rx_data, '0);
    checkOutput("arst_drop", PW'(rx_drop_cnt), PW'(0));
    tx_q.delete();
    rx_q.delete();
    @(negedge clk);
    reset = 1'b1;
    tick();
    checkOutput("post_txrdy", PW'(tx_rdy), PW'(1'b1));
    checkOutput("post_pndng", PW'(pndng), PW'(1'b0));
    checkOutput("post_rxvld", PW'(rx_vld), PW'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
